// File: rtl/lfsr_bank_pkg.sv
// Shared types, default maximal-length tap masks and the LFSR step function
// used by every channel of the bank.
package lfsr_bank_pkg;

    localparam int MAX_W = 32;

    // Maximal-length XNOR tap masks for W = 3..16 (bit k set: state[k] feeds the XNOR).
    // Each set includes bit 0 so the oldest sequence bit is always part of the recurrence.
    localparam logic [15:0] DEFAULT_TAPS [3:16] = '{
        16'h0003, 16'h0003, 16'h0005, 16'h0003, 16'h0003, 16'h001D, 16'h0011,
        16'h0009, 16'h0005, 16'h0941, 16'h1601, 16'h2A01, 16'h0003, 16'h100B
    };

    typedef struct packed {
        logic [MAX_W-1:0] next_state;
        logic             lockup;
    } lfsr_step_t;

    // One Fibonacci step over the low 'width' bits: feedback enters the MSB,
    // everything else shifts right. All-ones is the XNOR dead state, so it is
    // forced to all-zeros and reported.
    function automatic lfsr_step_t lfsr_next(input logic [MAX_W-1:0] state,
                                             input logic [MAX_W-1:0] taps,
                                             input int width);
        lfsr_step_t       r;
        logic [MAX_W-1:0] mask;
        logic             fb;
        for (int i = 0; i < MAX_W; i++) begin
            mask[i] = (i < width);
        end
        fb = ~^(state & taps & mask);
        r.next_state = '0;
        r.lockup     = 1'b0;
        for (int i = 0; i < MAX_W - 1; i++) begin
            if (i + 1 < width) begin
                r.next_state[i] = state[i + 1];
            end
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) begin
                r.next_state[i] = fb;
            end
        end
        if ((state & mask) == mask) begin
            r.next_state = '0;
            r.lockup     = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_bank_if.sv
// Control/status bundle between the game logic and the LFSR bank.
interface lfsr_bank_if #(
    parameter int W      = 4,
    parameter int NUM_CH = 1
);
    logic                hold;
    logic                step_req;
    logic                seed_load;
    logic [W-1:0]        seed_in;
    logic [NUM_CH*W-1:0] out;
    logic                step_o;
    logic                lockup_o;

    modport master (
        output hold, step_req, seed_load, seed_in,
        input  out, step_o, lockup_o
    );

    modport slave (
        input  hold, step_req, seed_load, seed_in,
        output out, step_o, lockup_o
    );
endinterface

// File: rtl/lfsr_bank_core.sv
// One LFSR channel: holds its state and a sticky lock-up flag.
module lfsr_bank_core
    import lfsr_bank_pkg::*;
#(
    parameter int           W    = 4,
    parameter logic [W-1:0] TAPS = W'(4'b1001)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reset_val,
    output logic [W-1:0] state,
    output logic         lockup
);

    logic [W-1:0] state_reg, state_next;
    logic         lockup_reg, lockup_next;
    lfsr_step_t   step_res;
    logic         unused_step_bits;

    assign step_res         = lfsr_next(MAX_W'(state_reg), MAX_W'(TAPS), W);
    assign unused_step_bits = ^step_res.next_state;

    // Load beats step; the lock-up flag only clears on load (or reset).
    always_comb begin
        state_next  = state_reg;
        lockup_next = lockup_reg;
        if (load) begin
            state_next  = load_val;
            lockup_next = 1'b0;
        end else if (step) begin
            state_next  = step_res.next_state[W-1:0];
            lockup_next = lockup_reg | step_res.lockup;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= reset_val;
            lockup_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lockup_reg <= lockup_next;
        end
    end

    assign state  = state_reg;
    assign lockup = lockup_reg;

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NUM_CH XNOR LFSRs advancing together on a shared prescaler tick,
// with hold, single-step request and runtime seed load.
module lfsr_bank
    import lfsr_bank_pkg::*;
#(
    parameter int           W      = 4,
    parameter logic [W-1:0] TAPS   = W'(4'b1001),
    parameter int           PERIOD = 3200,
    parameter int           NUM_CH = 1,
    parameter logic [W-1:0] SEED   = '0
) (
    input  logic        clk,
    input  logic        reset,
    lfsr_bank_if.slave  bus
);

    localparam int               CNT_W    = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_bank: TAPS must be non-zero");
    end
    if (PERIOD < 1) begin : g_bad_period
        $error("lfsr_bank: PERIOD must be at least 1");
    end
    if (W < 2 || W > MAX_W) begin : g_bad_width
        $error("lfsr_bank: W must be in 2..32");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_nch
        $error("lfsr_bank: NUM_CH must be in 1..8");
    end

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                step_o_reg, step_o_next;
    logic                step_fire;
    logic [NUM_CH*W-1:0] out_bus;
    logic [NUM_CH-1:0]   lock_vec;

    // Prescaler and step decision: seed_load > step_req > hold > count.
    // A step_req coinciding with the terminal count is one step, not two.
    always_comb begin
        cnt_next    = cnt_reg;
        step_o_next = 1'b0;
        step_fire   = 1'b0;
        if (bus.seed_load) begin
            cnt_next = '0;
        end else if (bus.step_req) begin
            step_fire   = 1'b1;
            step_o_next = 1'b1;
            cnt_next    = '0;
        end else if (bus.hold) begin
            cnt_next = cnt_reg;
        end else if (cnt_reg == CNT_LAST) begin
            step_fire   = 1'b1;
            step_o_next = 1'b1;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Prescaler count and the registered "new values valid" pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            step_o_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            step_o_reg <= step_o_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        lfsr_bank_core #(
            .W    (W),
            .TAPS (TAPS)
        ) u_core (
            .clk       (clk),
            .reset     (reset),
            .step      (step_fire),
            .load      (bus.seed_load),
            .load_val  (bus.seed_in ^ W'(gi)),
            .reset_val (SEED ^ W'(gi)),
            .state     (out_bus[gi*W +: W]),
            .lockup    (lock_vec[gi])
        );
    end

    assign bus.out      = out_bus;
    assign bus.step_o   = step_o_reg;
    assign bus.lockup_o = |lock_vec;

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: two configurations (PERIOD=4 / 2 channels, PERIOD=1 /
// 3 channels) checked every cycle against a behavioural model, plus directed
// scenarios with constant expectations.
module tb_lfsr_bank;

    localparam int         W      = 4;
    localparam int         A_CH   = 2;
    localparam int         A_PER  = 4;
    localparam logic [3:0] A_TAPS = 4'b1001;
    localparam logic [3:0] A_SEED = 4'h0;
    localparam int         B_CH   = 3;
    localparam int         B_PER  = 1;
    localparam logic [3:0] B_TAPS = 4'b0011;
    localparam logic [3:0] B_SEED = 4'h5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_bank_if #(.W(W), .NUM_CH(A_CH)) bus_a ();
    lfsr_bank_if #(.W(W), .NUM_CH(B_CH)) bus_b ();

    lfsr_bank #(.W(W), .TAPS(A_TAPS), .PERIOD(A_PER), .NUM_CH(A_CH), .SEED(A_SEED)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    lfsr_bank #(.W(W), .TAPS(B_TAPS), .PERIOD(B_PER), .NUM_CH(B_CH), .SEED(B_SEED)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tick_no  = 0;

    // Reference model: index 0 = bank A, 1 = bank B.
    int cfg_nch[2]  = '{A_CH, B_CH};
    int cfg_per[2]  = '{A_PER, B_PER};
    int cfg_taps[2] = '{int'(A_TAPS), int'(B_TAPS)};
    int cfg_seed[2] = '{int'(A_SEED), int'(B_SEED)};
    int m_ch[2][8];
    int m_cnt[2];
    int m_so[2];
    int m_lk[2];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    // Step rule: all-ones goes to zero (lock-up); otherwise the XNOR of the
    // tapped bits (even number of ones -> 1) enters at the top.
    function automatic int ref_step(input int s, input int taps);
        int fb;
        fb = ($countones(s & taps) % 2 == 0) ? 1 : 0;
        return (s >> 1) | (fb << (W - 1));
    endfunction

    task automatic model_edge(input int d, input bit rst, input bit ld, input int sin,
                              input bit sreq, input bit hld);
        if (rst) begin
            for (int i = 0; i < cfg_nch[d]; i++) m_ch[d][i] = (cfg_seed[d] ^ i) & 15;
            m_cnt[d] = 0; m_so[d] = 0; m_lk[d] = 0;
        end else if (ld) begin
            for (int i = 0; i < cfg_nch[d]; i++) m_ch[d][i] = (sin ^ i) & 15;
            m_cnt[d] = 0; m_so[d] = 0; m_lk[d] = 0;
        end else if (sreq || (!hld && m_cnt[d] == cfg_per[d] - 1)) begin
            for (int i = 0; i < cfg_nch[d]; i++) begin
                if (m_ch[d][i] == 15) begin
                    m_ch[d][i] = 0;
                    m_lk[d] = 1;
                end else begin
                    m_ch[d][i] = ref_step(m_ch[d][i], cfg_taps[d]);
                end
            end
            m_cnt[d] = 0; m_so[d] = 1;
        end else if (hld) begin
            m_so[d] = 0;
        end else begin
            m_cnt[d] = m_cnt[d] + 1; m_so[d] = 0;
        end
    endtask

    function automatic longint model_out(input int d);
        longint v = 0;
        for (int i = 0; i < cfg_nch[d]; i++) v = v | (longint'(m_ch[d][i]) << (i * W));
        return v;
    endfunction

    // One clock edge: sample the applied inputs, advance the model, compare.
    task automatic tick();
        bit r, a_h, a_sr, a_ld, b_h, b_sr, b_ld;
        int a_si, b_si;
        r = reset;
        a_h = bus_a.hold; a_sr = bus_a.step_req; a_ld = bus_a.seed_load; a_si = int'(bus_a.seed_in);
        b_h = bus_b.hold; b_sr = bus_b.step_req; b_ld = bus_b.seed_load; b_si = int'(bus_b.seed_in);
        @(posedge clk);
        model_edge(0, r, a_ld, a_si, a_sr, a_h);
        model_edge(1, r, b_ld, b_si, b_sr, b_h);
        #1;
        tick_no++;
        check("A.out",    longint'(bus_a.out),      model_out(0));
        check("A.step_o", longint'(bus_a.step_o),   longint'(m_so[0]));
        check("A.lockup", longint'(bus_a.lockup_o), longint'(m_lk[0]));
        check("B.out",    longint'(bus_b.out),      model_out(1));
        check("B.step_o", longint'(bus_b.step_o),   longint'(m_so[1]));
        check("B.lockup", longint'(bus_b.lockup_o), longint'(m_lk[1]));
        $display("tick %0d rst=%b | A hold=%b sreq=%b ld=%b sin=%h out=%h so=%b lk=%b | B hold=%b sreq=%b ld=%b sin=%h out=%h so=%b lk=%b",
                 tick_no, r, a_h, a_sr, a_ld, a_si[3:0], bus_a.out, bus_a.step_o, bus_a.lockup_o,
                 b_h, b_sr, b_ld, b_si[3:0], bus_b.out, bus_b.step_o, bus_b.lockup_o);
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        bus_a.hold = 1'b0; bus_a.step_req = 1'b0; bus_a.seed_load = 1'b0; bus_a.seed_in = '0;
        bus_b.hold = 1'b0; bus_b.step_req = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed_in = '0;
    endtask

    logic [3:0] seq_exp [15] = '{4'h8, 4'h4, 4'hA, 4'h5, 4'h2, 4'h9, 4'hC, 4'h6,
                                 4'hB, 4'hD, 4'hE, 4'h7, 4'h3, 4'h1, 4'h0};

    initial begin
        logic [3:0] seq_q[$];
        logic [3:0] prev;
        int first_change;
        int cnt_so;
        int wait_n;
        longint held_val;

        idle_inputs();
        reset = 1'b1;

        // Reset for two cycles.
        tick(); tick();
        check("rst_out_a", longint'(bus_a.out), 64'h10);
        check("rst_out_b", longint'(bus_b.out), 64'h745);
        check("rst_step_o", longint'(bus_a.step_o), 0);

        // Free-run 60 cycles: first change on edge 4, 15-step sequence back to 0.
        reset = 1'b0;
        prev = bus_a.out[3:0];
        first_change = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (first_change < 0 && bus_a.out[3:0] != prev) first_change = k;
            if (bus_a.step_o) seq_q.push_back(bus_a.out[3:0]);
        end
        check("first_step_edge", first_change, 4);
        check("seq_len", seq_q.size(), 15);
        for (int i = 0; i < 15 && i < seq_q.size(); i++) check($sformatf("seq[%0d]", i), seq_q[i], seq_exp[i]);

        // Hold after 2 of 4 counts; resume needs 2 more edges.
        tick(); tick();
        held_val = model_out(0);
        bus_a.hold = 1'b1;
        cnt_so = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            cnt_so += int'(bus_a.step_o);
            check("hold_frozen", longint'(bus_a.out), held_val);
        end
        check("hold_no_step_o", cnt_so, 0);
        bus_a.hold = 1'b0;
        wait_n = -1;
        for (int k = 1; k <= 8 && wait_n < 0; k++) begin
            tick();
            if (bus_a.step_o) wait_n = k;
        end
        check("hold_resume", wait_n, 2);

        // step_req while held: zero the state first, then one forced step.
        bus_a.seed_load = 1'b1; bus_a.seed_in = 4'h0;
        tick();
        bus_a.seed_load = 1'b0;
        bus_a.hold = 1'b1; bus_a.step_req = 1'b1;
        tick();
        check("sreq_hold_out", longint'(bus_a.out), 64'h08);
        check("sreq_hold_step_o", longint'(bus_a.step_o), 1);
        bus_a.step_req = 1'b0;
        tick();
        check("sreq_step_o_once", longint'(bus_a.step_o), 0);
        bus_a.hold = 1'b0;
        wait_n = -1;
        for (int k = 1; k <= 8 && wait_n < 0; k++) begin
            tick();
            if (bus_a.step_o) wait_n = k;
        end
        check("sreq_cnt_restart", wait_n, 4);

        // Seed load into the lock-up state, then step out of it.
        bus_a.seed_load = 1'b1; bus_a.seed_in = 4'hF;
        tick();
        check("seed_out", longint'(bus_a.out), 64'hEF);
        check("seed_lockup", longint'(bus_a.lockup_o), 0);
        bus_a.seed_load = 1'b0; bus_a.step_req = 1'b1;
        tick();
        bus_a.step_req = 1'b0;
        check("lockup_out", longint'(bus_a.out), 64'h70);
        check("lockup_flag", longint'(bus_a.lockup_o), 1);

        // Reset wins over seed_load and step_req.
        reset = 1'b1; bus_a.seed_load = 1'b1; bus_a.seed_in = 4'h9; bus_a.step_req = 1'b1;
        tick();
        check("rst_prio_out", longint'(bus_a.out), 64'h10);
        check("rst_prio_step_o", longint'(bus_a.step_o), 0);
        check("rst_prio_lockup", longint'(bus_a.lockup_o), 0);
        idle_inputs();

        // PERIOD=1 bank with hold toggling every cycle: one step per free cycle.
        cnt_so = 0;
        for (int k = 0; k < 20; k++) begin
            bus_b.hold = (k % 2 == 0);
            tick();
            cnt_so += int'(bus_b.step_o);
        end
        check("p1_toggle_steps", cnt_so, 10);
        idle_inputs();

        // Randomised traffic on both banks.
        for (int k = 0; k < 400; k++) begin
            reset           = ($urandom_range(0, 127) == 0);
            bus_a.hold      = ($urandom_range(0, 3) == 0);
            bus_a.step_req  = ($urandom_range(0, 15) == 0);
            bus_a.seed_load = ($urandom_range(0, 31) == 0);
            bus_a.seed_in   = 4'($urandom);
            bus_b.hold      = ($urandom_range(0, 2) == 0);
            bus_b.step_req  = ($urandom_range(0, 15) == 0);
            bus_b.seed_load = ($urandom_range(0, 31) == 0);
            bus_b.seed_in   = 4'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Parametrised bank of XNOR Fibonacci LFSRs, the pseudo-random source for game logic (spawn positions, obstacle patterns). It replaces the fixed 4-bit, fixed-divider generator and adds the following:
- configurable width, taps, divider period and channel count;
- per-channel distinct seeds and runtime seed load;
- a single-step request and lock-up recovery.

All channels advance together on a shared prescaler tick. The bank can be frozen by game-state hold inputs.

## Interface
- W, 4: LFSR width per channel (2..32).
- TAPS, 4'b1001: feedback mask, W bits; bit k set means state[k] feeds the XNOR.
- PERIOD, 3200: clocks per automatic step (≥1).
- NUM_CH, 1: number of independent channels (1..8).
- SEED, 0: base reset seed; channel i resets to SEED ^ W'(i).
---
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- hold  in  1  freeze: prescaler and all states held (pause / gameover OR'd externally).
- step_req  in  1  one-cycle request: force one step of all channels on this edge.
- seed_load  in  1  load seed_in into all channels.
- seed_in  in  W  runtime seed; channel i receives seed_in ^ W'(i).
- out  out  NUM_CH*W  channel i state at out[i*W +: W].
- step_o  out  1  high for exactly the cycle after every step (new values valid).
- lockup_o  out  1  sticky; set when any channel was found in the all-ones lock-up state; cleared by reset or seed_load.

## Operation
- Step function per channel: fb = ~^(state & TAPS); next = {fb, state[W-1:1]}.
- Lock-up: if a channel equals all-ones at a step, its next state is all-zeros instead, and lockup_o sets.
- Prescaler: cnt counts 0..PERIOD-1. At cnt==PERIOD-1 with no hold, a step occurs and cnt wraps to 0. With PERIOD=1, the bank steps every non-held cycle.
- Per-edge priority: reset > seed_load > step_req > hold > prescaler.
  - reset: out = SEED^i per channel, cnt=0, step_o=0, lockup_o=0.
  - seed_load: channels = seed_in^i, cnt=0, step_o=0, lockup_o=0. Hold is ignored.
  - step_req: step regardless of hold, cnt=0, step_o next cycle. If the prescaler would also fire on the same edge, the result is a single step only.
  - hold: cnt, out and lockup_o unchanged; step_o=0.
- No arithmetic beyond the cnt increment. cnt width is $clog2(PERIOD+1), with an explicit wrap and no modulo.

## Timing
- Reset values: out = {SEED^(NUM_CH-1), …, SEED^0}; step_o=0; lockup_o=0.
- After reset deassert, the first automatic step occurs on the PERIOD-th rising edge.
- out changes on the stepping edge. step_o is registered and is high during the following cycle only.
- Latency from step_req or seed_load to out is one edge.
- A hold asserted mid-count resumes the count where it stopped after hold drops. No tick is lost or duplicated.
- Reset mid-count discards the partial count.

## Structure
- lfsr_pkg:
  - default tap masks for maximal-length W = 3..16 (localparam array);
  - the function lfsr_next(state, taps) implementing the step with lock-up recovery.
- Sub-module lfsr_core: one channel, holding state and lock-up flag. Inputs: step, load, load_val, reset_val.
- lfsr_bank owns the shared prescaler and step_o, and instantiates NUM_CH lfsr_core via a generate loop.
- Assertions: TAPS ≠ 0, PERIOD ≥ 1, W ≥ 2.

## Test plan
- Sequence, W=4, TAPS=1001, PERIOD=4, NUM_CH=1, SEED=0:
  - stimulus: reset for 2 cycles, then 60 cycles free-running;
  - required: out is 0000, 1000, 0100, 1010, 0101, 0010, 1001, 1100, …; the first change is on the 4th edge; step_o pulses every 4 cycles; the sequence repeats with period 15.
- Hold mid-count: assert hold 10 cycles after 2 of 4 counts.
  - required: out is frozen and step_o=0 throughout the hold; the next step comes 2 edges after hold drops.
- step_req while hold=1:
  - required: exactly one step (0000→1000), step_o high for 1 cycle, cnt restarts at 0.
- seed_load with seed_in=1111, NUM_CH=2:
  - required: ch0=1111, ch1=1110, lockup_o=0.
  - At the next step: ch0→0000 and lockup_o=1; ch1 steps normally (1110→0111).
- Reset with seed_load and step_req all asserted:
  - required: reset values, step_o=0.
- PERIOD=1 with hold toggling every cycle:
  - required: exactly one step per non-held cycle.
